matrix_op_conv_gen: RTL and testbench
=====================================

// Module: matrix_op_conv_gen
// PURPOSE
//  Generalised 2-D convolution engine, the parametrised successor of the fixed 3x3 valid-only conv op.
//  Convolves image A (dim_m x dim_n) with a runtime-selected KxK kernel (K = 1, 3 or 5), stride 1 or 2,
//  in valid or zero-padded "same" mode, and writes result C to the shared matrix BRAM.
//  Kernel is cached locally once per run; accumulation result is wrapped or saturated per sat_mode.
//  Sits under the matrix ALU dispatcher beside the other matrix_op_* engines; it owns the BRAM port while busy.
// PARAMETERS
//  ELEMENT_WIDTH  `ELEMENT_WIDTH    unsigned element width (8)
//  ADDR_WIDTH     `BRAM_ADDR_WIDTH  BRAM address width
//  KMAX           5                 largest kernel side supported; sets cache depth KMAX*KMAX
//  ACC_WIDTH      24                accumulator width; >= 2*ELEMENT_WIDTH + clog2(KMAX*KMAX)
// PORTS
//  clk          in   1           clock
//  rst_n        in   1           reset, synchronous, active-low
//  start        in   1           level start request; sampled only in IDLE
//  done         out  1           high in DONE until start drops
//  busy         out  1           high in every state except IDLE/DONE
//  err          out  1           config error flag; valid while done=1
//  dim_m,dim_n  in   5           image rows/cols, 1..16; held stable while busy
//  k_size       in   3           kernel side; legal 1,3,5 (<=KMAX)
//  stride       in   2           legal 1,2
//  pad_same     in   1           0 = valid, 1 = same (zero pad P=(K-1)/2)
//  sat_mode     in   1           0 = wrap acc[EW-1:0], 1 = clamp to 2^EW-1
//  addr_op1     in   ADDR_WIDTH  image base, row-major
//  addr_op2     in   ADDR_WIDTH  kernel base, row-major KxK
//  addr_res     in   ADDR_WIDTH  result base, row-major out_m x out_n
//  mem_rd_en    out  1           read strobe; mem_rd_data valid the cycle after next (issue, wait, use)
//  mem_rd_addr  out  ADDR_WIDTH  read address
//  mem_rd_data  in   ELEMENT_WIDTH
//  mem_wr_en    out  1           one-cycle write strobe
//  mem_wr_addr  out  ADDR_WIDTH
//  mem_wr_data  out  ELEMENT_WIDTH
//  cycle_count  out  32          cycles spent busy in last run; held until next start
// BEHAVIOUR
//  Reset (rst_n low at posedge): state IDLE; every output, acc, indices and cache cleared to 0. Mid-run reset aborts; no further writes.
//  Output dims: valid: out=((dim-K)>>(stride-1))+1; same: out=(dim+stride-1)>>(stride-1).
//  Config check in IDLE on start: K not in {1,3,5} or K>KMAX, stride not in {1,2}, dim=0 or >16, or (valid and dim<K)
//   -> err<=1, go straight to DONE, no reads or writes, cycle_count<=0. Else err<=0, cycle counter<=0.
//  States: IDLE -> K_RD -> K_WAIT -> K_CAP (repeat for K*K taps) -> P_INIT -> [T_RD -> T_WAIT -> T_MAC | T_SKIP] per tap
//   -> P_WRITE -> P_NEXT -> P_INIT... -> DONE -> IDLE when start=0.
//  Source pixel: r = i*stride + ki - P, c = j*stride + kj - P (P=0 valid); signed 7-bit compare against dims.
//  In-bounds tap: 3 cycles (read addr addr_op1+r*dim_n+c, wait, acc+=pixel*cache[ki*K+kj]).
//  Out-of-bounds tap (same mode only): 1 cycle T_SKIP, no read, acc unchanged.
//  P_WRITE: mem_wr_en=1 one cycle, addr addr_res+i*out_n+j, data wrap/sat of acc. Exactly out_m*out_n writes, in raster order.
//  mem_rd_en and mem_wr_en never high together; each is a one-cycle pulse.
//  Product and accumulator unsigned, full ACC_WIDTH, no intermediate truncation.
//  cycle_count = number of cycles in states other than IDLE/DONE; latched on entry to DONE.
//  start held high through DONE does not retrigger; a new run requires start low then high.
//  Run time = 3*K*K + sum_pixels(3 + 3*inb + oob).
// STRUCTURE
//  matrix_pkg.vh: CONV_KMAX, state encodings CONV_S_*, legal K/stride constants, ACC_WIDTH default.
//  Sub-module conv_out_fmt: combinational ACC_WIDTH -> ELEMENT_WIDTH wrap/saturate; kernel cache and FSM stay in top.
// TESTING
//  4x4 all 1, K=3 all 1, valid, s=1, wrap -> 4 writes of 9 at addr_res..+3; cycle_count=147.
//  3x3 all 1, K=3 all 1, same, s=1 -> [4 6 4;6 9 6;4 6 4]; no reads at out-of-bounds taps.
//  4x4 all 200, K=3 all 2, valid -> sat_mode=0 writes 16 (3600 mod 256); sat_mode=1 writes 255.
//  5x5 ramp 0..24, K=3 identity (center 1), valid, s=2 -> 2x2 [6 8;16 18].
//  k_size=4 or stride=0 -> done=1, err=1, zero writes, cycle_count=0; following legal run clears err.
//  rst_n low for 1 cycle mid-pixel of a 6x6 run -> all outputs 0 next cycle, no writes, IDLE; rerun gives correct result.

Source files
------------

// File: rtl/matrix_op_conv_gen_pkg.sv
// Shared constants, FSM state encoding and source-coordinate helpers for the
// generalised KxK convolution engine.
package matrix_op_conv_gen_pkg;

  localparam int CONV_KMAX      = 5;
  localparam int CONV_ACC_WIDTH = 24;
  localparam int CONV_MAX_DIM   = 16;

  localparam logic [1:0] CONV_STRIDE_1 = 2'd1;
  localparam logic [1:0] CONV_STRIDE_2 = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_K_RD,
    S_K_WAIT,
    S_K_CAP,
    S_P_INIT,
    S_T_RD,
    S_T_WAIT,
    S_T_MAC,
    S_T_SKIP,
    S_P_WRITE,
    S_P_NEXT,
    S_DONE
  } conv_state_e;

  function automatic logic kernelLegal(input logic [2:0] k, input int kmax);
    return (k == 3'd1 || k == 3'd3 || k == 3'd5) && (int'(k) <= kmax);
  endfunction

  // Image coordinate of a tap: outIdx*stride + kOff - pad, wrapped into signed 7 bits.
  function automatic logic signed [6:0] srcCoord(input logic [4:0] outIdx,
                                                 input logic [2:0] kOff,
                                                 input logic       strideTwo,
                                                 input logic [2:0] pad);
    logic [6:0] base;
    base = strideTwo ? {1'b0, outIdx, 1'b0} : {2'b00, outIdx};
    return $signed(base + {4'b0000, kOff} - {4'b0000, pad});
  endfunction

  function automatic logic inRange(input logic signed [6:0] coord, input logic [4:0] dim);
    return !coord[6] && (coord[5:0] < {1'b0, dim});
  endfunction

endpackage

// File: rtl/matrix_op_conv_gen_out_fmt.sv
// Reduces the full-width accumulator to one element, either wrapping (low bits)
// or clamping to the largest unsigned element value.
module matrix_op_conv_gen_out_fmt #(
  parameter int ELEMENT_WIDTH = 8,
  parameter int ACC_WIDTH     = 24
) (
  input  logic [ACC_WIDTH-1:0]     acc_i,
  input  logic                     sat_mode_i,
  output logic [ELEMENT_WIDTH-1:0] data_o
);

  localparam logic [ACC_WIDTH-1:0] MaxVal =
    {{(ACC_WIDTH-ELEMENT_WIDTH){1'b0}}, {ELEMENT_WIDTH{1'b1}}};

  always_comb begin
    data_o = acc_i[ELEMENT_WIDTH-1:0];
    if (sat_mode_i && (acc_i > MaxVal)) data_o = '1;
  end

endmodule

// File: rtl/matrix_op_conv_gen.sv
// Generalised 2-D convolution engine: caches a KxK kernel, then walks the output
// raster reading in-bounds taps from BRAM and writing one formatted result per pixel.
module matrix_op_conv_gen
  import matrix_op_conv_gen_pkg::*;
#(
  parameter int ELEMENT_WIDTH = 8,
  parameter int ADDR_WIDTH    = 12,
  parameter int KMAX          = CONV_KMAX,
  parameter int ACC_WIDTH     = CONV_ACC_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  output logic                     done_o,
  output logic                     busy_o,
  output logic                     err_o,
  input  logic [4:0]               dim_m_i,
  input  logic [4:0]               dim_n_i,
  input  logic [2:0]               k_size_i,
  input  logic [1:0]               stride_i,
  input  logic                     pad_same_i,
  input  logic                     sat_mode_i,
  input  logic [ADDR_WIDTH-1:0]    addr_op1_i,
  input  logic [ADDR_WIDTH-1:0]    addr_op2_i,
  input  logic [ADDR_WIDTH-1:0]    addr_res_i,
  output logic                     mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0]    mem_rd_addr_o,
  input  logic [ELEMENT_WIDTH-1:0] mem_rd_data_i,
  output logic                     mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0]    mem_wr_addr_o,
  output logic [ELEMENT_WIDTH-1:0] mem_wr_data_o,
  output logic [31:0]              cycle_count_o
);

  localparam int KDEPTH = KMAX * KMAX;

  conv_state_e state_q, state_d;
  logic [2:0]  ki_q, ki_d, kj_q, kj_d;
  logic [4:0]  tap_q, tap_d;
  logic [4:0]  i_q, i_d, j_q, j_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic        err_q, err_d;
  logic [31:0] cnt_q, cnt_d, cycCount_q, cycCount_d;
  logic [ELEMENT_WIDTH-1:0] cache_q [KDEPTH];

  logic        cfgErr, strideTwo, lastTap, lookInb, lastCol, lastRow;
  logic [2:0]  padAmt, nextKi, nextKj, lookKi, lookKj;
  logic [4:0]  nextTap;
  logic [5:0]  kSq, diffM, diffN, outM, outN;
  logic signed [6:0] curR, curC, lookR, lookC;
  logic [ACC_WIDTH-1:0] product;
  logic [ELEMENT_WIDTH-1:0] fmtData;

  assign strideTwo = (stride_i == CONV_STRIDE_2);
  assign padAmt    = pad_same_i ? ((k_size_i - 3'd1) >> 1) : 3'd0;
  assign kSq       = 6'(k_size_i) * 6'(k_size_i);

  assign cfgErr = !kernelLegal(k_size_i, KMAX)
                || !(stride_i == CONV_STRIDE_1 || stride_i == CONV_STRIDE_2)
                || (dim_m_i == 5'd0) || (dim_m_i > 5'(CONV_MAX_DIM))
                || (dim_n_i == 5'd0) || (dim_n_i > 5'(CONV_MAX_DIM))
                || (!pad_same_i && ((dim_m_i < 5'(k_size_i)) || (dim_n_i < 5'(k_size_i))));

  // Dividing by the stride is a right shift since stride is 1 or 2.
  assign diffM = {1'b0, dim_m_i} - 6'(k_size_i);
  assign diffN = {1'b0, dim_n_i} - 6'(k_size_i);
  assign outM  = pad_same_i ? (strideTwo ? (({1'b0, dim_m_i} + 6'd1) >> 1) : {1'b0, dim_m_i})
                            : ((strideTwo ? (diffM >> 1) : diffM) + 6'd1);
  assign outN  = pad_same_i ? (strideTwo ? (({1'b0, dim_n_i} + 6'd1) >> 1) : {1'b0, dim_n_i})
                            : ((strideTwo ? (diffN >> 1) : diffN) + 6'd1);

  assign lastTap = ({1'b0, tap_q} == kSq - 6'd1);
  assign nextKj  = (kj_q == k_size_i - 3'd1) ? 3'd0 : kj_q + 3'd1;
  assign nextKi  = (kj_q == k_size_i - 3'd1) ? ki_q + 3'd1 : ki_q;
  assign nextTap = tap_q + 5'd1;
  assign lastCol = ({1'b0, j_q} == outN - 6'd1);
  assign lastRow = ({1'b0, i_q} == outM - 6'd1);

  // P_INIT decides on tap (0,0); the tap states decide on the tap that follows.
  assign lookKi  = (state_q == S_P_INIT) ? ki_q : nextKi;
  assign lookKj  = (state_q == S_P_INIT) ? kj_q : nextKj;
  assign curR    = srcCoord(i_q, ki_q, strideTwo, padAmt);
  assign curC    = srcCoord(j_q, kj_q, strideTwo, padAmt);
  assign lookR   = srcCoord(i_q, lookKi, strideTwo, padAmt);
  assign lookC   = srcCoord(j_q, lookKj, strideTwo, padAmt);
  assign lookInb = inRange(lookR, dim_m_i) && inRange(lookC, dim_n_i);

  assign product = ACC_WIDTH'(mem_rd_data_i) * ACC_WIDTH'(cache_q[tap_q]);

  matrix_op_conv_gen_out_fmt #(
    .ELEMENT_WIDTH(ELEMENT_WIDTH),
    .ACC_WIDTH    (ACC_WIDTH)
  ) u_out_fmt (
    .acc_i     (acc_q),
    .sat_mode_i(sat_mode_i),
    .data_o    (fmtData)
  );

  assign done_o        = (state_q == S_DONE);
  assign busy_o        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign err_o         = err_q;
  assign cycle_count_o = cycCount_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    ki_d          = ki_q;
    kj_d          = kj_q;
    tap_d         = tap_q;
    i_d           = i_q;
    j_d           = j_q;
    acc_d         = acc_q;
    err_d         = err_q;
    cnt_d         = cnt_q;
    cycCount_d    = cycCount_q;
    mem_rd_en_o   = 1'b0;
    mem_rd_addr_o = '0;
    mem_wr_en_o   = 1'b0;
    mem_wr_addr_o = '0;
    mem_wr_data_o = '0;
    if (busy_o) cnt_d = cnt_q + 32'd1;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          ki_d  = '0;
          kj_d  = '0;
          tap_d = '0;
          i_d   = '0;
          j_d   = '0;
          acc_d = '0;
          if (cfgErr) begin
            err_d      = 1'b1;
            cycCount_d = '0;
            state_d    = S_DONE;
          end else begin
            err_d   = 1'b0;
            cnt_d   = '0;
            state_d = S_K_RD;
          end
        end
      end
      S_K_RD: begin
        mem_rd_en_o   = 1'b1;
        mem_rd_addr_o = addr_op2_i + ADDR_WIDTH'(tap_q);
        state_d       = S_K_WAIT;
      end
      S_K_WAIT: state_d = S_K_CAP;
      S_K_CAP: begin
        {ki_d, kj_d, tap_d} = lastTap ? '0 : {nextKi, nextKj, nextTap};
        state_d = lastTap ? S_P_INIT : S_K_RD;
      end
      S_P_INIT: begin
        acc_d   = '0;
        state_d = lookInb ? S_T_RD : S_T_SKIP;
      end
      S_T_RD: begin
        mem_rd_en_o   = 1'b1;
        mem_rd_addr_o = addr_op1_i + ADDR_WIDTH'($unsigned(curR)) * ADDR_WIDTH'(dim_n_i)
                        + ADDR_WIDTH'($unsigned(curC));
        state_d       = S_T_WAIT;
      end
      S_T_WAIT: state_d = S_T_MAC;
      S_T_MAC, S_T_SKIP: begin
        if (state_q == S_T_MAC) acc_d = acc_q + product;
        {ki_d, kj_d, tap_d} = lastTap ? '0 : {nextKi, nextKj, nextTap};
        if (lastTap) state_d = S_P_WRITE;
        else         state_d = lookInb ? S_T_RD : S_T_SKIP;
      end
      S_P_WRITE: begin
        mem_wr_en_o   = 1'b1;
        mem_wr_addr_o = addr_res_i + ADDR_WIDTH'(i_q) * ADDR_WIDTH'(outN) + ADDR_WIDTH'(j_q);
        mem_wr_data_o = fmtData;
        state_d       = S_P_NEXT;
      end
      S_P_NEXT: begin
        state_d = S_P_INIT;
        if (lastCol) begin
          j_d = '0;
          if (lastRow) begin
            i_d        = '0;
            cycCount_d = cnt_q + 32'd1;
            state_d    = S_DONE;
          end else begin
            i_d = i_q + 5'd1;
          end
        end else begin
          j_d = j_q + 5'd1;
        end
      end
      S_DONE: if (!start_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ki_q       <= '0;
      kj_q       <= '0;
      tap_q      <= '0;
      i_q        <= '0;
      j_q        <= '0;
      acc_q      <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      cycCount_q <= '0;
    end else begin
      ki_q       <= ki_d;
      kj_q       <= kj_d;
      tap_q      <= tap_d;
      i_q        <= i_d;
      j_q        <= j_d;
      acc_q      <= acc_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      cycCount_q <= cycCount_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int t = 0; t < KDEPTH; t++) cache_q[t] <= '0;
    end else if (state_q == S_K_CAP) begin
      cache_q[tap_q] <= mem_rd_data_i;
    end
  end

endmodule

// File: tb/tb_matrix_op_conv_gen.sv
// Bench for matrix_op_conv_gen: directed table vectors, randomized runs against a
// loop-level convolution model, and reset / start-hold corner sequences.
module tb_matrix_op_conv_gen;

  localparam int LOG_DEPTH = 4096;
  localparam int DONE_BOUND = 8000;

  typedef struct {
    int m, n, k, s;
    bit pad, sat;
    int op1, op2, res;
  } cfg_t;

  typedef struct {
    cfg_t c;
    int imgKind;
    int kerKind;
    int expCycles;
    int expWrites;
    logic [0:8][7:0] expData;
  } vec_t;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic        done, busy, err;
  logic [4:0]  dim_m = '0, dim_n = '0;
  logic [2:0]  k_size = '0;
  logic [1:0]  stride = '0;
  logic        pad_same = 1'b0, sat_mode = 1'b0;
  logic [11:0] addr_op1 = '0, addr_op2 = '0, addr_res = '0;
  logic        mem_rd_en, mem_wr_en;
  logic [11:0] mem_rd_addr, mem_wr_addr;
  logic [7:0]  mem_rd_data, mem_wr_data;
  logic [31:0] cycle_count;

  logic [7:0]  mem [0:4095];
  logic [7:0]  rdPipe = '0, rdData = '0;
  logic [19:0] wrLog [0:LOG_DEPTH-1];
  int          rdCount = 0, wrCount = 0, hazardCount = 0;
  logic        wrPrev = 1'b0, rdPrev = 1'b0;

  int          checks = 0, errors = 0;
  bit          expErr;
  int          expCycles, expReads;
  logic [19:0] expQ [$];

  assign mem_rd_data = rdData;

  matrix_op_conv_gen dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .done_o(done), .busy_o(busy), .err_o(err),
    .dim_m_i(dim_m), .dim_n_i(dim_n), .k_size_i(k_size), .stride_i(stride),
    .pad_same_i(pad_same), .sat_mode_i(sat_mode),
    .addr_op1_i(addr_op1), .addr_op2_i(addr_op2), .addr_res_i(addr_res),
    .mem_rd_en_o(mem_rd_en), .mem_rd_addr_o(mem_rd_addr), .mem_rd_data_i(mem_rd_data),
    .mem_wr_en_o(mem_wr_en), .mem_wr_addr_o(mem_wr_addr), .mem_wr_data_o(mem_wr_data),
    .cycle_count_o(cycle_count)
  );

  always #5 clk = ~clk;

  // BRAM model with issue/wait/use read latency, plus a write log and strobe hazard counter.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      rdPipe  <= mem[mem_rd_addr];
      rdCount <= rdCount + 1;
    end
    rdData <= rdPipe;
    if (mem_wr_en) begin
      wrLog[wrCount % LOG_DEPTH] <= {mem_wr_addr, mem_wr_data};
      wrCount <= wrCount + 1;
    end
    if ((mem_rd_en && mem_wr_en) || (mem_wr_en && wrPrev) || (mem_rd_en && rdPrev))
      hazardCount <= hazardCount + 1;
    wrPrev <= mem_wr_en;
    rdPrev <= mem_rd_en;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic finishSim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Reference convolution straight from the definition: loop over output pixels and taps.
  task automatic modelRun(input cfg_t c);
    int p, outM, outN, acc, r, cc, px, val;
    expQ.delete();
    expCycles = 0;
    expReads  = 0;
    expErr = !(c.k == 1 || c.k == 3 || c.k == 5) || !(c.s == 1 || c.s == 2)
             || c.m < 1 || c.m > 16 || c.n < 1 || c.n > 16
             || (!c.pad && (c.m < c.k || c.n < c.k));
    if (expErr) return;
    p    = c.pad ? (c.k - 1) / 2 : 0;
    outM = c.pad ? (c.m + c.s - 1) / c.s : (c.m - c.k) / c.s + 1;
    outN = c.pad ? (c.n + c.s - 1) / c.s : (c.n - c.k) / c.s + 1;
    expCycles = 3 * c.k * c.k;
    expReads  = c.k * c.k;
    for (int i = 0; i < outM; i++) begin
      for (int j = 0; j < outN; j++) begin
        acc = 0;
        px  = 3;
        for (int ki = 0; ki < c.k; ki++) begin
          for (int kj = 0; kj < c.k; kj++) begin
            r  = i * c.s + ki - p;
            cc = j * c.s + kj - p;
            if (r >= 0 && r < c.m && cc >= 0 && cc < c.n) begin
              acc += int'(mem[c.op1 + r * c.n + cc]) * int'(mem[c.op2 + ki * c.k + kj]);
              px += 3;
              expReads++;
            end else begin
              px += 1;
            end
          end
        end
        expCycles += px;
        val = c.sat ? ((acc > 255) ? 255 : acc) : (acc % 256);
        expQ.push_back({12'(c.res + i * outN + j), 8'(val)});
      end
    end
  endtask

  task automatic fillMem(input cfg_t c, input int imgKind, input int kerKind);
    for (int a = 0; a < c.m * c.n; a++)
      mem[c.op1 + a] = (imgKind == 0) ? 8'd1 : (imgKind == 1) ? 8'd200 :
                       (imgKind == 2) ? 8'(a) : 8'($urandom_range(0, 255));
    for (int a = 0; a < c.k * c.k; a++)
      mem[c.op2 + a] = (kerKind == 0) ? 8'd1 : (kerKind == 1) ? 8'd2 :
                       (kerKind == 2) ? ((a == (c.k * c.k) / 2) ? 8'd1 : 8'd0) :
                       8'($urandom_range(0, 255));
  endtask

  // One full run: start, bounded wait for done, compare against the model, then
  // hold start in DONE to confirm no retrigger and release it.
  task automatic applyStimulus(input cfg_t c, output int wr0);
    int rd0, hz0, waitCycles, nWr, rdHold;
    modelRun(c);
    dim_m    = 5'(c.m);
    dim_n    = 5'(c.n);
    k_size   = 3'(c.k);
    stride   = 2'(c.s);
    pad_same = c.pad;
    sat_mode = c.sat;
    addr_op1 = 12'(c.op1);
    addr_op2 = 12'(c.op2);
    addr_res = 12'(c.res);
    rd0 = rdCount;
    wr0 = wrCount;
    hz0 = hazardCount;
    start = 1'b1;
    waitCycles = 0;
    while (!done && waitCycles < DONE_BOUND) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    if (!done) begin
      checkOutput("doneTimeout", 64'(done), 64'd1);
      finishSim();
    end
    nWr = wrCount - wr0;
    checkOutput("err", 64'(err), 64'(expErr));
    checkOutput("busyAtDone", 64'(busy), 64'd0);
    checkOutput("cycleCount", 64'(cycle_count), 64'(expCycles));
    checkOutput("writeCount", 64'(nWr), 64'(expQ.size()));
    checkOutput("readCount", 64'(rdCount - rd0), 64'(expReads));
    checkOutput("strobeHazards", 64'(hazardCount - hz0), 64'd0);
    for (int w = 0; w < expQ.size() && w < nWr; w++)
      checkOutput($sformatf("write%0d", w), 64'(wrLog[(wr0 + w) % LOG_DEPTH]), 64'(expQ[w]));
    rdHold = rdCount;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("holdStartDone", 64'(done), 64'd1);
    checkOutput("holdStartNoRead", 64'(rdCount - rdHold), 64'd0);
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput("idleAfterDrop", 64'({done, busy}), 64'd0);
  endtask

  function automatic cfg_t mkCfg(input int m, n, k, s, input bit pad, sat);
    cfg_t c;
    c.m = m; c.n = n; c.k = k; c.s = s; c.pad = pad; c.sat = sat;
    c.op1 = 100; c.op2 = 600; c.res = 1000;
    return c;
  endfunction

  function automatic vec_t mkVec(input cfg_t c, input int imgKind, kerKind, cyc, nw,
                                 input logic [0:8][7:0] data);
    vec_t v;
    v.c = c; v.imgKind = imgKind; v.kerKind = kerKind;
    v.expCycles = cyc; v.expWrites = nw; v.expData = data;
    return v;
  endfunction

  initial begin
    vec_t vecs [8];
    cfg_t c;
    int   wr0, kPick, wrBefore;

    for (int a = 0; a < 4096; a++) mem[a] = '0;

    vecs[0] = mkVec(mkCfg(4, 4, 3, 1, 0, 0), 0, 0, 147, 4, {8'd9, 8'd9, 8'd9, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
    vecs[1] = mkVec(mkCfg(3, 3, 3, 1, 1, 0), 0, 0, 233, 9, {8'd4, 8'd6, 8'd4, 8'd6, 8'd9, 8'd6, 8'd4, 8'd6, 8'd4});
    vecs[2] = mkVec(mkCfg(4, 4, 3, 1, 0, 0), 1, 1, 147, 4, {8'd16, 8'd16, 8'd16, 8'd16, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
    vecs[3] = mkVec(mkCfg(4, 4, 3, 1, 0, 1), 1, 1, 147, 4, {8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
    vecs[4] = mkVec(mkCfg(5, 5, 3, 2, 0, 0), 2, 2, 147, 4, {8'd6, 8'd8, 8'd16, 8'd18, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
    vecs[5] = mkVec(mkCfg(4, 4, 4, 1, 0, 0), 0, 0, 0, 0, '0);
    vecs[6] = mkVec(mkCfg(4, 4, 3, 0, 0, 0), 0, 0, 0, 0, '0);
    vecs[7] = mkVec(mkCfg(4, 4, 1, 1, 0, 0), 0, 0, 99, 16, {8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1});

    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetFlags", 64'({done, busy, err, mem_rd_en, mem_wr_en}), 64'd0);
    checkOutput("resetCycleCount", 64'(cycle_count), 64'd0);
    checkOutput("resetAddrData", 64'({mem_rd_addr, mem_wr_addr, mem_wr_data}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 8; v++) begin
      fillMem(vecs[v].c, vecs[v].imgKind, vecs[v].kerKind);
      applyStimulus(vecs[v].c, wr0);
      checkOutput($sformatf("vec%0d_err", v), 64'(err), 64'(vecs[v].expWrites == 0));
      checkOutput($sformatf("vec%0d_cycles", v), 64'(cycle_count), 64'(vecs[v].expCycles));
      checkOutput($sformatf("vec%0d_writes", v), 64'(wrCount - wr0), 64'(vecs[v].expWrites));
      for (int w = 0; w < vecs[v].expWrites && w < 9; w++)
        checkOutput($sformatf("vec%0d_data%0d", v, w), 64'(wrLog[(wr0 + w) % LOG_DEPTH][7:0]),
                    64'(vecs[v].expData[w]));
    end

    // Abort a 6x6 run mid-pixel with a one-cycle reset, then rerun it cleanly.
    c = mkCfg(6, 6, 3, 1, 0, 0);
    fillMem(c, 3, 3);
    dim_m = 5'd6; dim_n = 5'd6; k_size = 3'd3; stride = 2'd1; pad_same = 1'b0; sat_mode = 1'b0;
    start = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    checkOutput("midRunBusy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput("abortFlags", 64'({done, busy, err, mem_rd_en, mem_wr_en}), 64'd0);
    checkOutput("abortOutputs", 64'({mem_rd_addr, mem_wr_addr, mem_wr_data, cycle_count}), 64'd0);
    rst_n = 1'b1;
    wrBefore = wrCount;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("abortNoWrites", 64'(wrCount - wrBefore), 64'd0);
    checkOutput("abortStaysIdle", 64'({done, busy}), 64'd0);
    applyStimulus(c, wr0);

    for (int run = 0; run < 12; run++) begin
      kPick = $urandom_range(0, 9);
      c.m   = $urandom_range(1, 8);
      c.n   = $urandom_range(1, 8);
      c.k   = (kPick < 3) ? 1 : (kPick < 6) ? 3 : (kPick < 9) ? 5 : 2 * $urandom_range(0, 2);
      c.s   = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 2);
      c.pad = 1'($urandom_range(0, 3) != 0);
      c.sat = 1'($urandom_range(0, 1));
      c.op1 = $urandom_range(0, 200);
      c.op2 = $urandom_range(500, 700);
      c.res = $urandom_range(1000, 2000);
      fillMem(c, 3, 3);
      applyStimulus(c, wr0);
    end

    finishSim();
  end

endmodule
